// File: rtl/fu_lsu_lq.sv
// Execute-stage load/store unit with an in-order load queue.
// Stores go straight to the store buffer. Loads either take a store-buffer
// bypass hit or issue one request to an in-order, variable-latency memory.
// Writeback is strictly in program order, one load per cycle.
module fu_lsu_lq #(
  parameter int WORD_SIZE_P  = 16,
  parameter int LQ_DEPTH     = 4,
  parameter int ROB_ENTRY    = 16,
  parameter int NUM_PHYS_REG = 32,
  parameter int SB_ENTRY     = 8,
  parameter int IMM_W        = 5,
  parameter int WIDTH_OP     = 4,
  parameter logic [WIDTH_OP-1:0] LDR_OP = WIDTH_OP'(1),
  parameter logic [WIDTH_OP-1:0] STR_OP = WIDTH_OP'(2),
  localparam int ROB_W = $clog2(ROB_ENTRY),
  localparam int REG_W = $clog2(NUM_PHYS_REG),
  localparam int SB_W  = $clog2(SB_ENTRY)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   exe_v_i,
  output logic                   exe_ready_o,
  input  logic [WIDTH_OP-1:0]    opcode_i,
  input  logic                   size_i,
  input  logic                   sign_i,
  input  logic [WORD_SIZE_P-1:0] operand1_i,
  input  logic [WORD_SIZE_P-1:0] operand2_i,
  input  logic [WORD_SIZE_P-1:0] imm_i,
  input  logic [ROB_W-1:0]       rob_dest_i,
  input  logic [REG_W-1:0]       reg_dest_i,
  input  logic [SB_W-1:0]        sb_dest_i,
  output logic [WORD_SIZE_P-1:0] byp_addr_o,
  output logic [SB_W-1:0]        byp_sb_num_o,
  input  logic                   byp_valid_i,
  input  logic [WORD_SIZE_P-1:0] byp_value_i,
  output logic                   mem_req_v_o,
  input  logic                   mem_req_ready_i,
  output logic [WORD_SIZE_P-1:0] mem_addr_o,
  input  logic                   mem_resp_v_i,
  input  logic [WORD_SIZE_P-1:0] mem_resp_data_i,
  output logic                   sb_v_o,
  output logic [SB_W-1:0]        sb_dest_o,
  output logic [WORD_SIZE_P-1:0] sb_addr_o,
  output logic [WORD_SIZE_P-1:0] sb_data_o,
  output logic                   sb_byte_o,
  output logic                   wb_v_o,
  output logic [ROB_W-1:0]       wb_rob_o,
  output logic [REG_W-1:0]       wb_dest_o,
  output logic [WORD_SIZE_P-1:0] wb_result_o,
  input  logic                   mispredict_i
);

  localparam int PTR_W  = $clog2(LQ_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DROP_W = PTR_W + 4;

  logic [CNT_W-1:0]  count, tf_count;
  logic [PTR_W-1:0]  head, tail, tf_head, tf_tail;
  logic [DROP_W-1:0] drop_cnt;
  logic [LQ_DEPTH-1:0] q_valid, q_done;

  logic [WORD_SIZE_P-1:0] q_data [LQ_DEPTH];
  logic [ROB_W-1:0]       q_rob  [LQ_DEPTH];
  logic [REG_W-1:0]       q_dst  [LQ_DEPTH];
  logic                   q_byte [LQ_DEPTH];
  logic                   q_sign [LQ_DEPTH];
  logic [PTR_W-1:0]       tf_mem [LQ_DEPTH];

  logic                   is_ld, is_st, accept, ld_acc, st_acc;
  logic [WORD_SIZE_P-1:0] ld_addr, st_addr, st_data;
  logic [PTR_W-1:0]       resp_idx;
  logic                   resp_fill, resp_drop, head_fill, pop;
  logic [WORD_SIZE_P-1:0] head_data, wb_data;

  // Issue handshake, address generation, bypass query and memory request.
  always_comb begin
    is_ld       = (opcode_i == LDR_OP);
    is_st       = (opcode_i == STR_OP);
    ld_addr     = operand1_i + imm_i;
    st_addr     = operand1_i + WORD_SIZE_P'(imm_i[WORD_SIZE_P-1 -: IMM_W]);
    st_data     = operand2_i;
    if (size_i) begin
      st_data      = '0;
      st_data[7:0] = operand2_i[7:0];
    end
    exe_ready_o  = !reset_i && (count < CNT_W'(LQ_DEPTH)) && mem_req_ready_i
                   && !mispredict_i;
    accept       = exe_v_i && exe_ready_o;
    ld_acc       = accept && is_ld;
    st_acc       = accept && is_st;
    byp_addr_o   = ld_addr;
    byp_sb_num_o = sb_dest_i;
    mem_req_v_o  = ld_acc && !byp_valid_i;
    mem_addr_o   = ld_addr;
  end

  // Response routing and head pop; a response filling the head is forwarded
  // so the load writes back the cycle after its data returns.
  always_comb begin
    resp_idx  = tf_mem[tf_head];
    resp_fill = mem_resp_v_i && !mispredict_i && (drop_cnt == '0) && (tf_count != '0);
    resp_drop = mem_resp_v_i && !mispredict_i && (drop_cnt != '0);
    head_fill = resp_fill && (resp_idx == head);
    pop       = !mispredict_i && q_valid[head] && (q_done[head] || head_fill);
    head_data = head_fill ? mem_resp_data_i : q_data[head];
    wb_data   = head_data;
    if (q_byte[head]) begin
      wb_data      = {WORD_SIZE_P{q_sign[head] & head_data[7]}};
      wb_data[7:0] = head_data[7:0];
    end
  end

  // Queue control, drop counter and registered store/writeback outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count <= '0; tf_count <= '0; head <= '0; tail <= '0;
      tf_head <= '0; tf_tail <= '0; drop_cnt <= '0;
      q_valid <= '0; q_done <= '0;
      sb_v_o <= 1'b0; sb_dest_o <= '0; sb_addr_o <= '0; sb_data_o <= '0; sb_byte_o <= 1'b0;
      wb_v_o <= 1'b0; wb_rob_o <= '0; wb_dest_o <= '0; wb_result_o <= '0;
    end else if (mispredict_i) begin
      // Everything in flight to memory becomes stale; a response in this
      // same cycle is one of them and is consumed here.
      count <= '0; tf_count <= '0; head <= '0; tail <= '0;
      tf_head <= '0; tf_tail <= '0;
      drop_cnt <= drop_cnt + DROP_W'(tf_count) - DROP_W'(mem_resp_v_i);
      q_valid <= '0; q_done <= '0;
      sb_v_o <= 1'b0;
      wb_v_o <= 1'b0;
    end else begin
      sb_v_o <= st_acc;
      if (st_acc) begin
        sb_dest_o <= sb_dest_i;
        sb_addr_o <= st_addr;
        sb_data_o <= st_data;
        sb_byte_o <= size_i;
      end
      if (resp_fill) begin
        q_done[resp_idx] <= 1'b1;
        tf_head          <= tf_head + 1'b1;
      end
      if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
      wb_v_o <= pop;
      if (pop) begin
        wb_rob_o      <= q_rob[head];
        wb_dest_o     <= q_dst[head];
        wb_result_o   <= wb_data;
        q_valid[head] <= 1'b0;
        q_done[head]  <= 1'b0;
        head          <= head + 1'b1;
      end
      if (ld_acc) begin
        q_valid[tail] <= 1'b1;
        q_done[tail]  <= byp_valid_i;
        tail          <= tail + 1'b1;
      end
      if (mem_req_v_o) tf_tail <= tf_tail + 1'b1;
      count    <= count + CNT_W'(ld_acc) - CNT_W'(pop);
      tf_count <= tf_count + CNT_W'(mem_req_v_o) - CNT_W'(resp_fill);
    end
  end

  // Entry payload and tag FIFO storage; validity is tracked above.
  always_ff @(posedge clk_i) begin
    if (ld_acc) begin
      q_data[tail] <= byp_value_i;
      q_rob[tail]  <= rob_dest_i;
      q_dst[tail]  <= reg_dest_i;
      q_byte[tail] <= size_i;
      q_sign[tail] <= sign_i;
    end
    if (resp_fill) q_data[resp_idx] <= mem_resp_data_i;
    if (mem_req_v_o) tf_mem[tf_tail] <= tail;
  end

endmodule

// File: tb/tb_fu_lsu_lq.sv
// Directed bench for fu_lsu_lq with a writeback scoreboard.
module tb_fu_lsu_lq;

  localparam logic [3:0] LDR = 4'd1;
  localparam logic [3:0] STR = 4'd2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        exe_v_i, exe_ready_o;
  logic [3:0]  opcode_i;
  logic        size_i, sign_i;
  logic [15:0] operand1_i, operand2_i, imm_i;
  logic [3:0]  rob_dest_i;
  logic [4:0]  reg_dest_i;
  logic [2:0]  sb_dest_i;
  logic [15:0] byp_addr_o;
  logic [2:0]  byp_sb_num_o;
  logic        byp_valid_i;
  logic [15:0] byp_value_i;
  logic        mem_req_v_o, mem_req_ready_i;
  logic [15:0] mem_addr_o;
  logic        mem_resp_v_i;
  logic [15:0] mem_resp_data_i;
  logic        sb_v_o;
  logic [2:0]  sb_dest_o;
  logic [15:0] sb_addr_o, sb_data_o;
  logic        sb_byte_o;
  logic        wb_v_o;
  logic [3:0]  wb_rob_o;
  logic [4:0]  wb_dest_o;
  logic [15:0] wb_result_o;
  logic        mispredict_i;

  fu_lsu_lq #(
    .WORD_SIZE_P(16), .LQ_DEPTH(4), .ROB_ENTRY(16), .NUM_PHYS_REG(32),
    .SB_ENTRY(8), .IMM_W(5), .WIDTH_OP(4), .LDR_OP(LDR), .STR_OP(STR)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .exe_v_i(exe_v_i), .exe_ready_o(exe_ready_o),
    .opcode_i(opcode_i), .size_i(size_i), .sign_i(sign_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i), .imm_i(imm_i),
    .rob_dest_i(rob_dest_i), .reg_dest_i(reg_dest_i), .sb_dest_i(sb_dest_i),
    .byp_addr_o(byp_addr_o), .byp_sb_num_o(byp_sb_num_o),
    .byp_valid_i(byp_valid_i), .byp_value_i(byp_value_i),
    .mem_req_v_o(mem_req_v_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
    .sb_v_o(sb_v_o), .sb_dest_o(sb_dest_o), .sb_addr_o(sb_addr_o),
    .sb_data_o(sb_data_o), .sb_byte_o(sb_byte_o),
    .wb_v_o(wb_v_o), .wb_rob_o(wb_rob_o), .wb_dest_o(wb_dest_o), .wb_result_o(wb_result_o),
    .mispredict_i(mispredict_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  rob;
    logic [4:0]  dst;
    logic [15:0] res;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  pend   = 0;   // requests sent to memory and not yet answered (stale included)

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every writeback must match the oldest outstanding expected load.
  always @(negedge clk_i) begin
    if (wb_v_o) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_v_o), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rob", 32'(wb_rob_o), 32'(e.rob));
        check("wb_dest", 32'(wb_dest_o), 32'(e.dst));
        check("wb_result", 32'(wb_result_o), 32'(e.res));
      end
    end
  end

  task automatic drive_ld(input logic [15:0] a, input logic [15:0] im, input logic sz,
                          input logic sg, input logic [3:0] rob, input logic [4:0] dst,
                          input logic [2:0] sbn, input logic bv, input logic [15:0] bval,
                          input logic [15:0] exp_addr, input logic [15:0] exp_res);
    wb_t e;
    logic req;
    exe_v_i = 1'b1; opcode_i = LDR; operand1_i = a; imm_i = im; size_i = sz; sign_i = sg;
    rob_dest_i = rob; reg_dest_i = dst; sb_dest_i = sbn; byp_valid_i = bv; byp_value_i = bval;
    #1;
    check("ld_ready", 32'(exe_ready_o), 32'd1);
    check("byp_addr", 32'(byp_addr_o), 32'(exp_addr));
    check("byp_sb_num", 32'(byp_sb_num_o), 32'(sbn));
    check("mem_req_v", 32'(mem_req_v_o), 32'(!bv));
    if (!bv) check("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
    req = mem_req_v_o;
    e.rob = rob; e.dst = dst; e.res = exp_res;
    exp_q.push_back(e);
    tick();
    if (req) pend++;
    exe_v_i = 1'b0; byp_valid_i = 1'b0;
  endtask

  task automatic resp(input logic [15:0] d);
    check("resp_protocol", 32'(pend > 0), 32'd1);
    mem_resp_v_i = 1'b1; mem_resp_data_i = d;
    tick();
    mem_resp_v_i = 1'b0;
    pend--;
  endtask

  initial begin
    reset_i = 1'b1; exe_v_i = 1'b0; opcode_i = '0; size_i = 1'b0; sign_i = 1'b0;
    operand1_i = '0; operand2_i = '0; imm_i = '0; rob_dest_i = '0; reg_dest_i = '0;
    sb_dest_i = '0; byp_valid_i = 1'b0; byp_value_i = '0; mem_req_ready_i = 1'b1;
    mem_resp_v_i = 1'b0; mem_resp_data_i = '0; mispredict_i = 1'b0;

    // Reset state
    repeat (3) tick();
    exe_v_i = 1'b1; opcode_i = LDR;
    #1;
    check("rst_ready", 32'(exe_ready_o), 32'd0);
    check("rst_sb_v", 32'(sb_v_o), 32'd0);
    check("rst_wb_v", 32'(wb_v_o), 32'd0);
    check("rst_wb_result", 32'(wb_result_o), 32'd0);
    check("rst_sb_addr", 32'(sb_addr_o), 32'd0);
    exe_v_i = 1'b0;
    tick();
    reset_i = 1'b0;
    #1;
    check("post_rst_ready", 32'(exe_ready_o), 32'd1);

    // 1: word load through memory, writeback one cycle after the response
    drive_ld(16'h0100, 16'h0004, 1'b0, 1'b0, 4'd1, 5'd2, 3'd0, 1'b0, 16'h0, 16'h0104, 16'hBEEF);
    tick(); tick();
    resp(16'hBEEF);
    check("t1_wb_latency", 32'(wb_v_o), 32'd1);
    tick();

    // 2: word store, then byte store with upper data bits cleared
    exe_v_i = 1'b1; opcode_i = STR; operand1_i = 16'h0010; imm_i = 16'h1800;
    operand2_i = 16'h1234; sb_dest_i = 3'd5; size_i = 1'b0;
    #1;
    check("st_no_mem_req", 32'(mem_req_v_o), 32'd0);
    tick();
    exe_v_i = 1'b0;
    check("st_sb_v", 32'(sb_v_o), 32'd1);
    check("st_sb_addr", 32'(sb_addr_o), 32'h0013);
    check("st_sb_data", 32'(sb_data_o), 32'h1234);
    check("st_sb_dest", 32'(sb_dest_o), 32'd5);
    check("st_sb_byte", 32'(sb_byte_o), 32'd0);
    exe_v_i = 1'b1; operand1_i = 16'hFFF0; imm_i = 16'hF800;
    operand2_i = 16'hABCD; sb_dest_i = 3'd7; size_i = 1'b1;
    tick();
    exe_v_i = 1'b0; size_i = 1'b0;
    check("stb_sb_addr", 32'(sb_addr_o), 32'h000F);
    check("stb_sb_data", 32'(sb_data_o), 32'h00CD);
    check("stb_sb_byte", 32'(sb_byte_o), 32'd1);
    tick();
    check("st_sb_v_drop", 32'(sb_v_o), 32'd0);

    // 3: byte loads from bypass, sign- and zero-extended
    drive_ld(16'h0040, 16'h0002, 1'b1, 1'b1, 4'd3, 5'd4, 3'd6, 1'b1, 16'h0080, 16'h0042, 16'hFF80);
    drive_ld(16'h0040, 16'h0002, 1'b1, 1'b0, 4'd4, 5'd5, 3'd2, 1'b1, 16'h0080, 16'h0042, 16'h0080);
    repeat (3) tick();

    // 4: fill the queue, fifth issue stalls, responses drain in order
    drive_ld(16'hFFFF, 16'h0002, 1'b0, 1'b0, 4'd5, 5'd6, 3'd0, 1'b0, 16'h0, 16'h0001, 16'hA001);
    drive_ld(16'h0200, 16'h0000, 1'b0, 1'b0, 4'd6, 5'd7, 3'd0, 1'b0, 16'h0, 16'h0200, 16'hA002);
    drive_ld(16'h1000, 16'hF000, 1'b1, 1'b0, 4'd7, 5'd8, 3'd0, 1'b0, 16'h0, 16'h0000, 16'h00F0);
    drive_ld(16'h0300, 16'h0010, 1'b1, 1'b1, 4'd8, 5'd9, 3'd0, 1'b0, 16'h0, 16'h0310, 16'hFFF0);
    exe_v_i = 1'b1; opcode_i = LDR;
    #1;
    check("full_ready", 32'(exe_ready_o), 32'd0);
    check("full_mem_req", 32'(mem_req_v_o), 32'd0);
    exe_v_i = 1'b0;
    tick();
    resp(16'hA001);
    resp(16'hA002);
    resp(16'h34F0);
    resp(16'h12F0);
    check("drain_ready", 32'(exe_ready_o), 32'd1);
    tick();

    // 5: bypass hit behind a pending memory load waits for it
    drive_ld(16'h0500, 16'h0000, 1'b0, 1'b0, 4'd9, 5'd10, 3'd0, 1'b0, 16'h0, 16'h0500, 16'h7777);
    drive_ld(16'h0600, 16'h0000, 1'b0, 1'b0, 4'd10, 5'd11, 3'd1, 1'b1, 16'h5555, 16'h0600, 16'h5555);
    tick(); tick();
    check("order_hold", 32'(wb_v_o), 32'd0);
    resp(16'h7777);
    check("order_a_wb", 32'(wb_v_o), 32'd1);
    tick();
    check("order_b_wb", 32'(wb_v_o), 32'd1);
    tick();

    // 6a: flush with two loads outstanding; stale responses are dropped
    drive_ld(16'h0700, 16'h0000, 1'b0, 1'b0, 4'd11, 5'd12, 3'd0, 1'b0, 16'h0, 16'h0700, 16'h1111);
    drive_ld(16'h0800, 16'h0000, 1'b0, 1'b0, 4'd12, 5'd13, 3'd0, 1'b0, 16'h0, 16'h0800, 16'h2222);
    mispredict_i = 1'b1; exe_v_i = 1'b1; opcode_i = STR; operand1_i = 16'h0020; imm_i = 16'h0000;
    #1;
    check("flush_ready", 32'(exe_ready_o), 32'd0);
    check("flush_mem_req", 32'(mem_req_v_o), 32'd0);
    exp_q.delete();
    tick();
    mispredict_i = 1'b0; exe_v_i = 1'b0;
    check("flush_sb_v", 32'(sb_v_o), 32'd0);
    check("flush_wb_v", 32'(wb_v_o), 32'd0);
    drive_ld(16'h0900, 16'h0000, 1'b0, 1'b0, 4'd13, 5'd14, 3'd0, 1'b0, 16'h0, 16'h0900, 16'h3333);
    resp(16'h1111);
    check("stale1_no_wb", 32'(wb_v_o), 32'd0);
    resp(16'h2222);
    check("stale2_no_wb", 32'(wb_v_o), 32'd0);
    resp(16'h3333);
    check("c_wb", 32'(wb_v_o), 32'd1);
    tick();

    // 6b: a response landing in the flush cycle is itself discarded
    drive_ld(16'h0A00, 16'h0000, 1'b0, 1'b0, 4'd14, 5'd15, 3'd0, 1'b0, 16'h0, 16'h0A00, 16'h4444);
    mispredict_i = 1'b1; mem_resp_v_i = 1'b1; mem_resp_data_i = 16'h4444;
    check("resp_protocol", 32'(pend > 0), 32'd1);
    exp_q.delete();
    tick();
    pend--;
    mispredict_i = 1'b0; mem_resp_v_i = 1'b0;
    check("flush_resp_wb_v", 32'(wb_v_o), 32'd0);
    drive_ld(16'h0B00, 16'h0001, 1'b0, 1'b0, 4'd15, 5'd16, 3'd0, 1'b0, 16'h0, 16'h0B01, 16'h5555);
    resp(16'h5555);
    check("c2_wb", 32'(wb_v_o), 32'd1);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    tick();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_lsu_lq.md
Name: fu_lsu_lq

Overview:
Parametrised next-generation load/store unit for the execute stage. Computes effective addresses and forwards stores to the store buffer. Loads go through an in-order load queue of depth LQ_DEPTH, so several loads can be outstanding against a variable-latency, in-order memory with a valid/ready request interface. Adds byte/word access size, sign/zero extension, backpressure to issue, and mispredict flush that discards stale memory responses.

Parameters:
WORD_SIZE_P, 16, datapath/address width (>=8)
LQ_DEPTH, 4, load-queue entries (power of 2, >=2)
ROB_ENTRY, 16, ROB entries; tag width $clog2(ROB_ENTRY)
NUM_PHYS_REG, 32, physical registers; dest width $clog2(NUM_PHYS_REG)
SB_ENTRY, 8, store-buffer entries; index width $clog2(SB_ENTRY)
IMM_W, 5, store offset field width taken from imm_i MSBs

Ports:
clk_i  in  1  clock, all state on posedge
reset_i  in  1  synchronous active-high reset
exe_v_i  in  1  issue valid
exe_ready_o  out  1  issue accepted when exe_v_i && exe_ready_o
opcode_i  in  WIDTH_OP  `LDR_OP or `STR_OP; others treated as no-op (accepted, no effect)
size_i  in  1  0=word, 1=byte
sign_i  in  1  byte load: 1=sign-extend, 0=zero-extend
operand1_i  in  WORD_SIZE_P  base address
operand2_i  in  WORD_SIZE_P  store data
imm_i  in  WORD_SIZE_P  immediate
rob_dest_i  in  $clog2(ROB_ENTRY)  ROB tag
reg_dest_i  in  $clog2(NUM_PHYS_REG)  load destination
sb_dest_i  in  $clog2(SB_ENTRY)  store-buffer slot (store) / bypass bound (load)
byp_addr_o  out  WORD_SIZE_P  bypass query address (comb)
byp_sb_num_o  out  $clog2(SB_ENTRY)  bypass query slot (comb)
byp_valid_i  in  1  same-cycle bypass hit
byp_value_i  in  WORD_SIZE_P  bypass data
mem_req_v_o  out  1  memory read request (comb)
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  WORD_SIZE_P  request address
mem_resp_v_i  in  1  read response, in request order
mem_resp_data_i  in  WORD_SIZE_P  response data
sb_v_o  out  1  store write to store buffer (registered)
sb_dest_o  out  $clog2(SB_ENTRY)  store slot
sb_addr_o  out  WORD_SIZE_P  store address
sb_data_o  out  WORD_SIZE_P  store data (byte: upper bits zeroed)
sb_byte_o  out  1  store size
wb_v_o  out  1  load writeback valid (registered)
wb_rob_o  out  $clog2(ROB_ENTRY)  writeback ROB tag
wb_dest_o  out  $clog2(NUM_PHYS_REG)  writeback register
wb_result_o  out  WORD_SIZE_P  writeback data
mispredict_i  in  1  flush

Behaviour:
- Reset: every registered output is 0. Queue is empty; count, pointers and drop counter are 0. exe_ready_o is forced 0 while reset_i is high.
- exe_ready_o = (count < LQ_DEPTH) && mem_req_ready_i && !mispredict_i. count is the registered value, so a same-cycle pop does not free space.
- Address: load uses operand1_i + imm_i. Store uses operand1_i + zero-extended imm_i[WORD_SIZE_P-1 -: IMM_W]. Both are modulo 2^WORD_SIZE_P.
- Store accept: the next cycle drives sb_v_o=1 with dest/addr/data/byte. Stores never enter the queue.
- Load accept, same cycle:
  - byp_addr_o=address, byp_sb_num_o=sb_dest_i; byp_* are don't-care in non-load cycles.
  - On byp_valid_i, write the entry done with byp_value_i and issue no memory request.
  - Otherwise mem_req_v_o=1 with mem_addr_o=address, write the entry pending, and push its index to an in-order tag FIFO.
- Memory response: fills the entry at the tag-FIFO head and marks it done, then pops the tag FIFO.
- Writeback: when the queue head is done, pop it. wb_v_o=1 the next cycle with the head's rob/dest/result. At most one writeback per cycle, strictly in program order; a done entry behind a pending head waits.
- Byte load result: {ext, data[7:0]}, where ext = sign_i ? data[7] replicated : 0. The extension is applied at writeback for both bypass and memory data. Word result passes through unmodified.
- Pointers wrap modulo LQ_DEPTH. Push and pop in the same cycle leave count unchanged.
- Mispredict in cycle T:
  - The issue in T is ignored.
  - All queue entries and the tag FIFO are cleared.
  - sb_v_o and wb_v_o are 0 in T+1.
  - drop_cnt is loaded with the number of outstanding memory requests.
  - While drop_cnt>0, each mem_resp_v_i decrements drop_cnt and is discarded. New loads may issue meanwhile; in-order memory guarantees stale responses arrive first.
  - A response arriving in T itself is counted as discarded.
- mem_resp_v_i with no outstanding request and drop_cnt==0 is a protocol error; the bench asserts it never happens.

Test Plan:
1. Reset, then word load: op1=0x0100, imm=0x0004, no bypass, response 0xBEEF after 3 cycles -> mem_addr_o=0x0104; wb_v_o=1 one cycle after the response, wb_result_o=0xBEEF.
2. Store: op1=0x0010, imm=0x1800 (IMM_W field=3), op2=0x1234, sb_dest=5 -> next cycle sb_v_o=1, sb_addr_o=0x0013, sb_data_o=0x1234, sb_dest_o=5.
3. Byte load, sign_i=1, bypass hit value 0x0080 -> no mem_req_v_o; wb_result_o=0xFF80. Repeat with sign_i=0 -> 0x0080.
4. Issue 4 loads with mem_resp held off -> exe_ready_o=0 on the 5th attempt. Return 4 responses -> 4 writebacks in issue order, ready reasserted.
5. Load A (memory), then load B (bypass hit) -> B is not written back before A; wb order A, B.
6. Two loads outstanding, mispredict, then new load C issued and 3 responses 0x1111, 0x2222, 0x3333 -> only C written back, with 0x3333; no wb_v_o in the flush+1 cycle.
